// File: rtl/sub_32bit_seq.sv
// Multi-cycle 32-bit subtractor: a - b computed as a + ~b + 1, CHUNK bits per clock,
// with a registered carry between chunks and a start/busy/done handshake.
module sub_32bit_seq #(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        overflow,
    output logic        zero
);

    // state | meaning
    // IDLE  | waiting for start; result outputs hold the last operation
    // RUN   | one CHUNK-wide slice of the difference per clock, LSB slice first
    // DONE  | done pulse cycle; start ignored

    localparam int N  = 32 / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [31:0]   MASK32 = 32'((64'd1 << CHUNK) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic            carry;
    logic [CW-1:0]   cnt;

    int              sh;
    logic [31:0]     a_shr;
    logic [31:0]     b_shr;
    logic [CHUNK:0]  sum;
    logic [31:0]     diff_nxt;

    // Slice selection by shifting keeps every select constant-ranged for any CHUNK.
    always_comb begin
        sh       = int'(cnt) * CHUNK;
        a_shr    = op_a >> sh;
        b_shr    = op_b >> sh;
        sum      = {1'b0, a_shr[CHUNK-1:0]} + {1'b0, b_shr[CHUNK-1:0]}
                 + (CHUNK+1)'(carry);
        diff_nxt = (diff & ~(MASK32 << sh)) | (32'(sum[CHUNK-1:0]) << sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff  <= diff_nxt;
                    carry <= sum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        borrow   <= ~sum[CHUNK];
                        // op_b holds ~b, so equal sign bits here mean a and b differ in sign
                        overflow <= (op_a[31] == op_b[31]) && (diff_nxt[31] != op_a[31]);
                        zero     <= (diff_nxt == 32'd0);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_32bit_seq.md
# sub_32bit_seq

Multi-cycle 32-bit subtractor that computes a - b as a + ~b + 1, CHUNK bits per clock, with a registered carry between chunks. It is the inverse-operation companion to the 32-bit ripple-carry adder in the arithmetic library. Other datapaths use it where a full 32-bit combinational carry chain would break timing. The start/busy/done handshake also lets it run under a self-checking bench, without the exhaustive combinational sweep used for the adder.

## Interface
- CHUNK, default 8: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32. N = 32/CHUNK.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  32  minuend, unsigned or two's complement; sampled with start.
- b  input  32  subtrahend; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result valid.
- diff  output  32  a - b modulo 2^32.
- borrow  output  1  1 when a < b as unsigned, i.e. the inverted final carry.
- overflow  output  1  signed overflow: a[31] != b[31] and diff[31] != a[31].
- zero  output  1  diff == 0.

## Operation
- FSM states and transitions:
  - IDLE -> RUN when start=1. On that edge: latch a into op_a, latch ~b into op_b, set carry to 1, set cnt to 0.
  - RUN: each edge computes {c, s} = op_a[chunk cnt] + op_b[chunk cnt] + carry with a CHUNK-bit ripple. s is written into diff[cnt*CHUNK +: CHUNK], carry takes c, and cnt increments.
  - RUN -> DONE on the edge that processes chunk N-1. On that same edge, borrow, overflow and zero are registered from the final values.
  - DONE -> IDLE unconditionally on the next edge.
- Chunks are processed least significant first.
- start is ignored in RUN and DONE. It is not queued.
- a and b may change freely after the accepting edge.
- diff, borrow, overflow and zero hold their last values until the next accepted start.
- During RUN, diff is partially updated and not valid. Only done=1 qualifies the flag outputs.
- Arithmetic is modulo 2^32; carry out of bit 31 is used only for borrow.
- The carry register is 1 bit. cnt width is clog2(N), with a minimum of 1.
- Reset values:
  - state=IDLE, busy=0, done=0.
  - diff=0, borrow=0, overflow=0, zero=0.
  - carry=0, cnt=0, op_a=0, op_b=0.
- Reset during RUN or DONE aborts the operation. No done pulse follows, and outputs take their reset values on that edge.
- rst has priority over start on the same edge.

## Timing
- Start accepted at edge k. busy is high from edge k through edge k+N+1, and low after that edge.
- Chunk j is written at edge k+1+j. The final chunk is written at edge k+N.
- done is high for exactly one cycle, between edges k+N and k+N+1. With CHUNK=8 that is 4 cycles of compute and done at edge k+4; with CHUNK=32, done at edge k+1.
- Latency from the accepting edge to done is N edges.
- Back-to-back throughput is one operation per N+2 cycles. The earliest next accept is the edge after DONE, at k+N+2, with start held high.
- start=1 during the done cycle is not accepted.
- The design is fully synchronous with no combinational path from inputs to outputs.

## Test plan
- CHUNK=8, a=5, b=3, start for 1 cycle -> done exactly 4 edges after accept. Outputs: diff=0x00000002, borrow=0, overflow=0, zero=0.
- a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, overflow=0, zero=0. Repeat with a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, overflow=1.
- a=b=0xDEADBEEF -> diff=0, zero=1, borrow=0. Also a=0x000000FF, b=0x00000100, which exercises borrow ripple across a chunk boundary -> diff=0xFFFFFFFF, borrow=1.
- Start pulsed again 2 cycles after accept, with different operands -> ignored. Exactly one done pulse, carrying the first operation's result. busy is continuous from accept through the done cycle.
- rst asserted 2 cycles after accept -> next edge: busy=0, diff=0, no done pulse. A new start after reset with a=10, b=4 -> diff=6 after 4 edges.
- CHUNK=1 and CHUNK=32, random 1000 pairs each, checked against a - b, borrow and overflow from a reference model -> done latency is 32 and 1 edges respectively, and all results match.
